// File: rtl/adc_frame_capture.sv
// ADC frame capture: samples ad_data on a programmable clock-enable, averages
// 2^S raw samples per stored sample, buffers one frame of DEPTH samples, then
// streams the frame out with valid/ready/last handshaking.
module adc_frame_capture #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 12,
    parameter int DIV_W  = 16,
    parameter int OUT_W  = 16
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DIV_W-1:0]  div_ratio,
    input  logic [1:0]        avg_shift,
    input  logic              start,
    input  logic              abort,
    output logic [OUT_W-1:0]  m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ACC_W = DATA_W + 3;   // holds 8 full-scale samples

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] ad_q;
    logic [DIV_W-1:0]  ratio_m1, div_cnt;
    logic [1:0]        shift;
    logic [2:0]        grp_cnt, grp_last;
    logic [ACC_W-1:0]  acc, acc_sum;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              rd_issued_all;
    logic [DATA_W-1:0] mem [DEPTH];

    logic go, tick, grp_end, wr_last, rd_load, last_hs;

    assign go       = (state == IDLE) && start && !abort;
    assign tick     = (state == CAPTURE) && (div_cnt == ratio_m1);
    assign grp_end  = tick && (grp_cnt == grp_last);
    assign wr_last  = grp_end && (wr_ptr == '1);
    assign acc_sum  = acc + ACC_W'(ad_q);
    assign wr_data  = DATA_W'(acc_sum >> shift);
    // Output register refills whenever it is empty or being consumed, so the
    // stream runs at one sample per cycle with no bubbles.
    assign rd_load  = (state == STREAM) && !rd_issued_all && (!m_tvalid || m_tready);
    assign last_hs  = (state == STREAM) && m_tvalid && m_tready && m_tlast;
    assign busy     = (state != IDLE);

    // Last tick index of an averaging group (2^S - 1)
    always_comb begin
        grp_last = 3'd0;
        case (shift)
            2'd0: grp_last = 3'd0;
            2'd1: grp_last = 3'd1;
            2'd2: grp_last = 3'd3;
            2'd3: grp_last = 3'd7;
            default: grp_last = 3'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk_50m) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go)      state_nxt = CAPTURE;
            CAPTURE: if (wr_last) state_nxt = STREAM;
            STREAM:  if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Sample register, divider, accumulator, pointers and stream output stage
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            ad_q          <= '0;
            ratio_m1      <= '0;
            shift         <= '0;
            div_cnt       <= '0;
            grp_cnt       <= '0;
            acc           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_issued_all <= 1'b0;
            m_tdata       <= '0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            ad_q       <= ad_data;
            frame_done <= 1'b0;

            if (go) begin
                ratio_m1      <= (div_ratio == '0) ? '0 : div_ratio - DIV_W'(1);
                shift         <= avg_shift;
                div_cnt       <= '0;
                grp_cnt       <= '0;
                acc           <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                rd_issued_all <= 1'b0;
            end

            if (state == CAPTURE) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (grp_end) begin
                    acc     <= '0;
                    grp_cnt <= '0;
                    wr_ptr  <= wr_ptr + ADDR_W'(1);
                end else if (tick) begin
                    acc     <= acc_sum;
                    grp_cnt <= grp_cnt + 3'd1;
                end
            end

            if (rd_load) begin
                m_tdata  <= OUT_W'(mem[rd_ptr]);
                m_tvalid <= 1'b1;
                m_tlast  <= (rd_ptr == '1);
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                if (rd_ptr == '1) rd_issued_all <= 1'b1;
            end else if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end

            if (last_hs) frame_done <= 1'b1;

            if (abort) begin
                m_tdata    <= '0;
                m_tvalid   <= 1'b0;
                m_tlast    <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

    // Frame buffer write; contents need no reset
    always_ff @(posedge clk_50m) begin
        if (grp_end) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture with a 16-sample frame.
module tb_adc_frame_capture;
    localparam int DATA_W = 10;
    localparam int ADDR_W = 4;
    localparam int DIV_W  = 16;
    localparam int OUT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_50m = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] ad_data = '0;
    logic [DIV_W-1:0]  div_ratio = '0;
    logic [1:0]        avg_shift = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic              busy;
    logic              frame_done;

    int tests = 0;
    int fails = 0;

    adc_frame_capture #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .OUT_W(OUT_W)
    ) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .ad_data(ad_data),
        .div_ratio(div_ratio), .avg_shift(avg_shift), .start(start),
        .abort(abort), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
        .frame_done(frame_done)
    );

    always #10 clk_50m = ~clk_50m;

    // One frame: stored sample i must equal base + step*i.
    // pat 0: ramp p(j)=j, 1: alternating 100/104, 2: constant 1023.
    // rdy 0: always ready, 1: random 50%.
    typedef struct {
        logic [DIV_W-1:0] div;
        logic [1:0]       shift;
        int               pat;
        int               rdy;
        int               base;
        int               step;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat_val(input int pat, input int j);
        logic [31:0] jj;
        jj = j;
        case (pat)
            0:       pat_val = jj[DATA_W-1:0];
            1:       pat_val = (j % 2 == 0) ? 10'd100 : 10'd104;
            default: pat_val = 10'd1023;
        endcase
    endfunction

    // ad_data = p(j) during the j-th cycle after the start cycle (j=0).
    // mode 0: plain frame, 1: start pulsed during STREAM, 2: reset after 3 handshakes
    task automatic run_frame(input vec_t v, input int mode);
        int j, idx;
        logic hold, hold_last, want_done, poked, finished;
        logic [OUT_W-1:0] hold_data;
        @(posedge clk_50m); #1;
        div_ratio = v.div;
        avg_shift = v.shift;
        ad_data   = pat_val(v.pat, 0);
        start     = 1'b1;
        j = 0; idx = 0; hold = 1'b0; hold_last = 1'b0; hold_data = '0;
        want_done = 1'b0; poked = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_50m); #1;
            start     = 1'b0;
            div_ratio = 16'd7;      // later changes must not affect this frame
            avg_shift = 2'd3;
            if (!rst_n) begin
                chk("rst_tvalid", m_tvalid, 0);
                chk("rst_tlast", m_tlast, 0);
                chk("rst_tdata", m_tdata, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", frame_done, 0);
                rst_n = 1'b1;
                finished = 1'b1;
                break;
            end
            if (want_done) begin
                chk("frame_done", frame_done, 1);
                chk("tvalid_after", m_tvalid, 0);
                chk("busy_after", busy, 0);
                finished = 1'b1;
                break;
            end
            if (frame_done) chk("early_done", frame_done, 0);
            if (hold) begin
                chk("hold_data", m_tdata, hold_data);
                chk("hold_last", m_tlast, hold_last);
            end
            j++;
            ad_data  = pat_val(v.pat, j);
            m_tready = (v.rdy == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 1 && m_tvalid && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (mode == 2 && idx == 3) begin
                rst_n = 1'b0;
                continue;
            end
            if (m_tvalid && m_tready) begin
                chk("sample", m_tdata, v.base + v.step * idx);
                chk("tlast", m_tlast, (idx == DEPTH - 1) ? 1 : 0);
                idx++;
                if (idx == DEPTH) want_done = 1'b1;
            end
            hold      = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_last = m_tlast;
        end
        if (!finished) chk("frame_timeout", idx, DEPTH);
        m_tready = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        logic bad;
        //            div    shift pat rdy base  step
        vecs[0] = '{16'd3, 2'd0, 0, 0, 2,    3};  // tick on ad_q=p(3m-1)
        vecs[1] = '{16'd0, 2'd0, 0, 0, 0,    1};  // 0 behaves as 1
        vecs[2] = '{16'd1, 2'd0, 0, 1, 0,    1};
        vecs[3] = '{16'd1, 2'd2, 1, 0, 102,  0};  // (100+104+100+104)/4
        vecs[4] = '{16'd1, 2'd1, 0, 0, 0,    2};  // (0+1)>>1 truncates to 0
        vecs[5] = '{16'd1, 2'd3, 0, 1, 3,    8};  // 28>>3=3, 92>>3=11
        vecs[6] = '{16'd2, 2'd1, 2, 1, 1023, 0};
        vecs[7] = '{16'd3, 2'd0, 0, 1, 2,    3};
        vecs[8] = '{16'd2, 2'd3, 2, 0, 1023, 0};  // 8*1023 must not overflow

        // Reset state
        repeat (3) @(posedge clk_50m);
        #1;
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_tlast", m_tlast, 0);
        chk("reset_tdata", m_tdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        rst_n = 1'b1;

        // Start together with abort in IDLE: stays idle
        @(posedge clk_50m); #1;
        div_ratio = 16'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk_50m); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);

        // Table-driven frames
        for (int i = 0; i < 9; i++) run_frame(vecs[i], 0);

        // Abort mid-capture around sample 7, then a clean second frame
        @(posedge clk_50m); #1;
        div_ratio = 16'd1; avg_shift = 2'd0; start = 1'b1;
        @(posedge clk_50m); #1;
        start = 1'b0;
        repeat (7) @(posedge clk_50m);
        #1;
        chk("capture_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk_50m); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tvalid", m_tvalid, 0);
        bad = 1'b0;
        m_tready = 1'b1;
        repeat (40) begin
            @(posedge clk_50m); #1;
            if (m_tvalid || frame_done || busy) bad = 1'b1;
        end
        m_tready = 1'b0;
        chk("abort_quiet", bad, 0);
        run_frame(vecs[0], 0);

        // Start during STREAM is ignored
        run_frame(vecs[2], 1);
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk_50m); #1;
            if (busy || m_tvalid) bad = 1'b1;
        end
        chk("restart_ignored", bad, 0);

        // Reset during STREAM, then a normal frame
        run_frame(vecs[1], 2);
        run_frame(vecs[3], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
